// File: rtl/serial_mag_compare.sv
// serial_mag_compare
//   MSB-first serial magnitude comparator. Consumes the per-bit
//   smaller/equal/greater flags of an upstream 1-bit comparator, one bit pair
//   per accepted cycle, and after WIDTH accepted bits reports A<B, A==B or A>B.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      begin a comparison (honoured only in IDLE)
//   in_valid   upstream flags valid (honoured only in COMPARE)
//   smaller_in upstream a_bit < b_bit
//   equal_in   upstream a_bit == b_bit
//   greater_in upstream a_bit > b_bit
//   busy       high while comparing
//   done       one-cycle pulse, result valid from this cycle on
//   smaller    registered result A < B
//   equal      registered result A == B
//   greater    registered result A > B
//   err        sticky: a non-one-hot flag triple was accepted
module serial_mag_compare #(
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic in_valid,
  input  logic smaller_in,
  input  logic equal_in,
  input  logic greater_in,
  output logic busy,
  output logic done,
  output logic smaller,
  output logic equal,
  output logic greater,
  output logic err
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;
  typedef enum logic [1:0] {UNDEC, LT, GT} dec_t;

  state_t          state, state_nxt;
  dec_t            dec, dec_nxt;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            last;
  logic            onehot;

  always_comb begin
    accept  = (state == COMPARE) && in_valid;
    onehot  = $onehot({smaller_in, equal_in, greater_in});
    last    = accept && (cnt == CW'(WIDTH - 1));
    // The first one-hot differing bit from the MSB decides; later bits never do.
    dec_nxt = dec;
    if (accept && onehot && (dec == UNDEC)) begin
      if (smaller_in)      dec_nxt = LT;
      else if (greater_in) dec_nxt = GT;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = COMPARE;
      COMPARE: if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the state register only, so still glitch-free and
  // with no path from the inputs.
  always_comb begin
    busy = (state == COMPARE);
    done = (state == DONE);
  end

  // Datapath: counter, decision, sticky error and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      dec     <= UNDEC;
      err     <= 1'b0;
      smaller <= 1'b0;
      equal   <= 1'b0;
      greater <= 1'b0;
    end else if ((state == IDLE) && start) begin
      cnt <= '0;
      dec <= UNDEC;
      err <= 1'b0;
    end else if (accept) begin
      cnt <= cnt + CW'(1);
      dec <= dec_nxt;
      if (!onehot) err <= 1'b1;
      // Load from dec_nxt so the WIDTH-th bit itself can still decide.
      if (last) begin
        case (dec_nxt)
          LT:      {smaller, equal, greater} <= 3'b100;
          GT:      {smaller, equal, greater} <= 3'b001;
          default: {smaller, equal, greater} <= 3'b010;
        endcase
      end
    end
  end

endmodule
